srlzr_ctrl: RTL

//  Sequencing controller for the PISO serializer in the Transceiver/Serializer path. Accepts parallel

---
 rtl/srlzr_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/srlzr_ctrl.sv
// rtl/srlzr_ctrl.sv - sequencing controller for a PISO serializer
//
// Takes parallel words over a valid/ready handshake into a 1-entry buffer.
// Each word is launched with a one-cycle load pulse. It is then shifted out
// MSB first over N = DATA_WIDTH-1 cycles. Consecutive words are either
// back-to-back or separated by GAP_CYCLES idle cycles.
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      synchronous reset, ACTIVE-HIGH despite the name
//   en         1 = new words may be launched; 0 = finish current word, then hold
//   s_data     parallel word, [DATA_WIDTH-1] sent first
//   s_valid    upstream word valid
//   s_ready    buffer can take s_data this cycle
//   load       serializer load pulse, one cycle per word
//   x          serializer parallel input, valid while load=1, held otherwise
//   shift_en   serializer shift enable
//   bit_valid  serializer output carries a payload bit this cycle
//   bit_idx    index of the bit on the serializer output (N-1 down to 0)
//   word_done  pulse on the last bit of each word
//   busy       word in flight, gap running, or buffer occupied
module srlzr_ctrl #(
  parameter int DATA_WIDTH = 5,
  parameter int GAP_CYCLES = 0,
  localparam int IDX_W = (DATA_WIDTH - 1 > 1) ? $clog2(DATA_WIDTH - 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:1] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  load,
  output logic [DATA_WIDTH-1:1] x,
  output logic                  shift_en,
  output logic                  bit_valid,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  word_done,
  output logic                  busy
);

  localparam int N = DATA_WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(N - 1);
  localparam logic [3:0]       LAST_GAP = 4'(GAP_CYCLES - 1);
  localparam logic             NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_cnt, w_cnt_nxt;
  logic [3:0]            r_gcnt, w_gcnt_nxt;
  logic [DATA_WIDTH-1:1] r_buf;
  logic                  r_full;
  logic [DATA_WIDTH-1:1] r_x;

  logic w_last_bit;
  logic w_last_gap;
  logic w_slot;
  logic w_accept;

  assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);
  assign w_last_gap = (r_state == S_GAP) && (r_gcnt == LAST_GAP);
  // A new word may start from IDLE, on the last bit when there is no gap,
  // or on the final gap cycle.
  assign w_slot     = (r_state == S_IDLE) || (w_last_bit && NO_GAP) || w_last_gap;

  // Reset gates every output in the cycle it is asserted, so a reset mid-word
  // stops the serializer immediately.
  assign load      = !rst_n && r_full && en && w_slot;
  assign s_ready   = !rst_n && (!r_full || load);
  assign w_accept  = s_valid && s_ready;
  assign bit_valid = !rst_n && (r_state == S_SHIFT);
  assign shift_en  = bit_valid && !w_last_bit;
  assign word_done = bit_valid && w_last_bit;
  assign bit_idx   = bit_valid ? (LAST_BIT - r_cnt) : '0;
  assign x         = rst_n ? '0 : (load ? r_buf : r_x);
  assign busy      = !rst_n && ((r_state != S_IDLE) || r_full);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    if (load) begin
      w_state_nxt = S_SHIFT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (!w_last_bit) begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end else if (NO_GAP) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_gcnt_nxt  = '0;
          end
        end
        S_GAP: begin
          if (w_last_gap) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gcnt_nxt = r_gcnt + 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_x     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      if (load) begin
        r_x <= r_buf;
      end
      // Refill wins over drain so a load and accept in the same cycle keep
      // the buffer full with the newer word.
      if (w_accept) begin
        r_buf  <= s_data;
        r_full <= 1'b1;
      end else if (load) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule
